// File: rtl/skip_rev_input_conditioner.sv
// ---------------------------------------------------------------------------
// skip_rev_input_conditioner
//
// Front-end for the skip/reverse counter stage. Turns two raw, asynchronous,
// bouncy push-button inputs into clean single-cycle command pulses. One
// physical press advances the counter by exactly one modified step.
//
// Each channel has three parts:
//   - a 2-FF synchronizer on the raw input
//   - a debounce FSM (IDLE / CONFIRM_HIGH / HELD / CONFIRM_LOW)
//   - a registered pulse on the CONFIRM_HIGH -> HELD transition
//
// Optional feature, enabled by defining the macro AUTO_REPEAT_EN:
//   While a button stays in HELD, the channel emits a first repeat pulse
//   after REPEAT_DELAY cycles. It then emits another pulse every
//   REPEAT_PERIOD cycles. Without the macro, no repeat logic is built and
//   each accepted press gives exactly one pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES  number of equal synchronized samples needed to accept
//                    a level change (2..65535)
//   REPEAT_DELAY     cycles in HELD before the first auto-repeat pulse
//   REPEAT_PERIOD    cycles between later auto-repeat pulses (>= 2)
//
// Ports:
//   iClk       system clock, rising-edge active
//   iRst       asynchronous, active-high reset
//   iSkipRaw   raw skip button, asynchronous to iClk
//   iRevRaw    raw reverse button, asynchronous to iClk
//   oSkip      one-cycle skip command pulse
//   oRev       one-cycle reverse command pulse
//   oSkipHeld  debounced skip level
//   oRevHeld   debounced reverse level
// ---------------------------------------------------------------------------

// Single conditioning channel: synchronizer, debounce FSM, pulse generator.
module skip_rev_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CONFIRM_HIGH = 2'd1,
        HELD         = 2'd2,
        CONFIRM_LOW  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            pulse_q, pulse_d;
    logic            held_q, held_d;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_MAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] REP_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] REP_ONE         = RW'(1);

    // rep_phase_q is 0 while the initial delay runs. It is 1 once the
    // periodic repeat has started.
    logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
    logic            rep_phase_q, rep_phase_d;
`endif

    // Next-state logic. The FSM only ever looks at sync2_q. The debounce
    // counter never goes past CNT_LAST, because reaching CNT_LAST always
    // forces a state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        sync1_d = raw;
        sync2_d = sync1_q;
`ifdef AUTO_REPEAT_EN
        // The repeat state clears whenever the channel is not staying in
        // HELD. This covers HELD entry, HELD exit and CONFIRM_LOW.
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = CONFIRM_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            CONFIRM_HIGH: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = CONFIRM_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (!rep_phase_q) begin
                        if (rep_cnt_q == REP_DELAY_LAST) begin
                            pulse_d     = 1'b1;
                            rep_phase_d = 1'b1;
                            rep_cnt_d   = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_ONE;
                        end
                    end else begin
                        rep_phase_d = 1'b1;
                        if (rep_cnt_q == REP_PERIOD_LAST) begin
                            pulse_d   = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_ONE;
                        end
                    end
`endif
                end
            end
            CONFIRM_LOW: begin
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // The held level is computed from the next state. That way the
        // registered output changes on the same edge as the state.
        held_d = (state_d == HELD) || (state_d == CONFIRM_LOW);
    end

    // All channel state. Reset clears everything at once, so a press in
    // progress is dropped without a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            pulse_q     <= 1'b0;
            held_q      <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pulse_q     <= pulse_d;
            held_q      <= held_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
`endif
        end
    end

    assign pulse = pulse_q;
    assign held  = held_q;

endmodule

// Top level: two independent channels. There is no arbitration between
// them. A simultaneous press gives both pulses in the same cycle, and the
// downstream counter interprets that as a reverse-skip.
module skip_rev_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iSkipRaw,
    input  logic iRevRaw,
    output logic oSkip,
    output logic oRev,
    output logic oSkipHeld,
    output logic oRevHeld
);

    skip_rev_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_skip (
        .clk   (iClk),
        .rst   (iRst),
        .raw   (iSkipRaw),
        .pulse (oSkip),
        .held  (oSkipHeld)
    );

    skip_rev_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_rev (
        .clk   (iClk),
        .rst   (iRst),
        .raw   (iRevRaw),
        .pulse (oRev),
        .held  (oRevHeld)
    );

endmodule
